output_requant: RTL and testbench

Downstream stage of the 8×8 weight-stationary systolic array. Drains one finished output tile (ARRAY_SIZE rows of ACC_WIDTH partial sums) from the reverse skew buffer by pulsing its `output_read`. Applies per-column bias, rounding arithmetic right shift, optional ReLU and saturation to OUT_WIDTH. Streams the quantized rows to the next layer over a valid/ready interface, with credit-based back-pressure so no row is ever dropped.

---
 rtl/requant_pkg.sv | 19 +
 rtl/requant_lane.sv | 54 +++++
 rtl/output_requant.sv | 184 ++++++++++++++++++
 tb/tb_output_requant.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/requant_pkg.sv
// rtl/requant_pkg.sv - shared constants, FSM state and row type for the output requantizer
package requant_pkg;

   localparam int DEF_ARRAY_SIZE  = 8;
   localparam int DEF_ACC_WIDTH   = 32;
   localparam int DEF_OUT_WIDTH   = 8;
   localparam int DEF_SHIFT_WIDTH = 5;
   localparam int DEF_FIFO_DEPTH  = 4;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DRAIN,
      ST_FLUSH
   } state_t;

   // Element j of a row sits at bits [j*OUT_WIDTH +: OUT_WIDTH] of q_data.
   typedef logic signed [DEF_ARRAY_SIZE-1:0][DEF_OUT_WIDTH-1:0] q_row_t;

endpackage

// File: rtl/requant_lane.sv
// rtl/requant_lane.sv - one column: registered bias add, then rounding shift, ReLU and saturation
module requant_lane
   import requant_pkg::*;
#(
   parameter int ACC_WIDTH   = DEF_ACC_WIDTH,
   parameter int OUT_WIDTH   = DEF_OUT_WIDTH,
   parameter int SHIFT_WIDTH = DEF_SHIFT_WIDTH
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        i_load,
   input  logic signed [ACC_WIDTH-1:0] i_c,
   input  logic signed [ACC_WIDTH-1:0] i_bias,
   input  logic [SHIFT_WIDTH-1:0]      i_shift,
   input  logic                        i_relu,
   output logic signed [OUT_WIDTH-1:0] o_q
);

   localparam int SW = ACC_WIDTH + 1;
   localparam int RW = ACC_WIDTH + 2;

   logic signed [SW-1:0]        r_sum;
   logic signed [RW-1:0]        w_half;
   logic signed [RW-1:0]        w_rnd;
   logic signed [RW-1:0]        w_shf;
   logic signed [RW-1:0]        w_relu;
   logic [RW-OUT_WIDTH:0]       w_hi;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sum <= '0;
      end else if (i_load) begin
         r_sum <= {i_c[ACC_WIDTH-1], i_c} + {i_bias[ACC_WIDTH-1], i_bias};
      end
   end

   // One extra bit beyond the sum so the rounding constant cannot overflow.
   always_comb begin
      w_half = '0;
      if (i_shift != '0) begin
         w_half = RW'(1) << (i_shift - 1'b1);
      end
      w_rnd  = {r_sum[SW-1], r_sum} + w_half;
      w_shf  = w_rnd >>> i_shift;
      w_relu = (i_relu && w_shf[RW-1]) ? '0 : w_shf;
      w_hi   = w_relu[RW-1:OUT_WIDTH-1];
      o_q    = w_relu[OUT_WIDTH-1:0];
      if (!(w_hi == '0 || w_hi == '1)) begin
         o_q = w_relu[RW-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                            : {1'b0, {(OUT_WIDTH-1){1'b1}}};
      end
   end

endmodule

// File: rtl/output_requant.sv
// rtl/output_requant.sv - drains one array tile, requantizes each row and streams it with credit back-pressure
module output_requant
   import requant_pkg::*;
#(
   parameter int ARRAY_SIZE  = DEF_ARRAY_SIZE,
   parameter int ACC_WIDTH   = DEF_ACC_WIDTH,
   parameter int OUT_WIDTH   = DEF_OUT_WIDTH,
   parameter int SHIFT_WIDTH = DEF_SHIFT_WIDTH,
   parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   enable,
   input  logic                                   start,
   input  logic [SHIFT_WIDTH-1:0]                 shift,
   input  logic                                   relu_en,
   input  logic signed [ACC_WIDTH*ARRAY_SIZE-1:0] bias,
   output logic                                   busy,
   output logic                                   output_read,
   input  logic signed [ACC_WIDTH*ARRAY_SIZE-1:0] c_in,
   output logic                                   q_valid,
   input  logic                                   q_ready,
   output logic signed [OUT_WIDTH*ARRAY_SIZE-1:0] q_data,
   output logic                                   q_last
);

   localparam int CW = $clog2(ARRAY_SIZE + 1);
   localparam int FW = $clog2(FIFO_DEPTH + 1);
   localparam int OW = FW + 2;
   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int RW = OUT_WIDTH * ARRAY_SIZE;

   state_t                          r_state;
   logic                            r_busy;
   logic [CW-1:0]                   r_rd_cnt;
   logic [CW-1:0]                   r_pop_cnt;
   logic [1:0]                      r_inflight;
   logic [SHIFT_WIDTH-1:0]          r_shift;
   logic                            r_relu;
   logic [ACC_WIDTH*ARRAY_SIZE-1:0] r_bias;
   logic                            r_rd_d;
   logic                            r_rd_last_d;
   logic                            r_v1;
   logic                            r_last1;
   logic [RW-1:0]                   r_mem [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0]           r_last_mem;
   logic [PW-1:0]                   r_wr_ptr;
   logic [PW-1:0]                   r_rd_ptr;
   logic [FW-1:0]                   r_count;

   logic                            w_pop;
   logic                            w_push;
   logic                            w_load;
   logic                            w_credit;
   logic [OW-1:0]                   w_occ;
   logic [RW-1:0]                   w_row;

   assign w_pop  = q_valid & q_ready;
   assign w_push = r_v1 & enable;
   assign w_load = r_rd_d & enable;

   // A read is only issued if its row is guaranteed a FIFO slot once it lands.
   assign w_occ    = OW'(r_count) + OW'(r_inflight) - OW'(w_pop);
   assign w_credit = w_occ < OW'(FIFO_DEPTH);
   assign output_read = (r_state == ST_DRAIN) & enable &
                        (r_rd_cnt < CW'(ARRAY_SIZE)) & w_credit;

   assign busy    = r_busy;
   assign q_valid = (r_count != '0);
   assign q_data  = q_valid ? r_mem[r_rd_ptr] : '0;
   assign q_last  = q_valid & r_last_mem[r_rd_ptr];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= ST_IDLE;
         r_busy    <= 1'b0;
         r_rd_cnt  <= '0;
         r_pop_cnt <= '0;
         r_shift   <= '0;
         r_relu    <= 1'b0;
         r_bias    <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_state   <= ST_DRAIN;
                  r_busy    <= 1'b1;
                  r_rd_cnt  <= '0;
                  r_pop_cnt <= '0;
                  r_shift   <= shift;
                  r_relu    <= relu_en;
                  r_bias    <= bias;
               end
            end
            ST_DRAIN: begin
               if (output_read) begin
                  r_rd_cnt <= r_rd_cnt + 1'b1;
                  if (r_rd_cnt == CW'(ARRAY_SIZE - 1)) begin
                     r_state <= ST_FLUSH;
                  end
               end
               if (w_pop) begin
                  r_pop_cnt <= r_pop_cnt + 1'b1;
               end
            end
            ST_FLUSH: begin
               if (w_pop) begin
                  r_pop_cnt <= r_pop_cnt + 1'b1;
                  if (r_pop_cnt == CW'(ARRAY_SIZE - 1)) begin
                     r_state <= ST_IDLE;
                     r_busy  <= 1'b0;
                  end
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   // Read strobe and last-row flag travel alongside the lane data; everything freezes with enable.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rd_d      <= 1'b0;
         r_rd_last_d <= 1'b0;
         r_v1        <= 1'b0;
         r_last1     <= 1'b0;
         r_inflight  <= '0;
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
      end else begin
         if (enable) begin
            r_rd_d      <= output_read;
            r_rd_last_d <= output_read & (r_rd_cnt == CW'(ARRAY_SIZE - 1));
            r_v1        <= r_rd_d;
            r_last1     <= r_rd_last_d;
         end
         case ({output_read, w_push})
            2'b10:   r_inflight <= r_inflight + 2'd1;
            2'b01:   r_inflight <= r_inflight - 2'd1;
            default: r_inflight <= r_inflight;
         endcase
         if (w_push) begin
            r_wr_ptr <= (r_wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= (r_rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr]      <= w_row;
         r_last_mem[r_wr_ptr] <= r_last1;
      end
   end

   for (genvar j = 0; j < ARRAY_SIZE; j++) begin : g_lane
      requant_lane #(
         .ACC_WIDTH   (ACC_WIDTH),
         .OUT_WIDTH   (OUT_WIDTH),
         .SHIFT_WIDTH (SHIFT_WIDTH)
      ) u_lane (
         .clk     (clk),
         .rst     (rst),
         .i_load  (w_load),
         .i_c     (c_in[j*ACC_WIDTH +: ACC_WIDTH]),
         .i_bias  (r_bias[j*ACC_WIDTH +: ACC_WIDTH]),
         .i_shift (r_shift),
         .i_relu  (r_relu),
         .o_q     (w_row[j*OUT_WIDTH +: OUT_WIDTH])
      );
   end

endmodule

// File: tb/tb_output_requant.sv
// tb/tb_output_requant.sv - directed and randomized self-checking bench for output_requant
module tb_output_requant;
   import requant_pkg::*;

   localparam int N  = DEF_ARRAY_SIZE;
   localparam int AW = DEF_ACC_WIDTH;
   localparam int OW = DEF_OUT_WIDTH;
   localparam int SW = DEF_SHIFT_WIDTH;
   localparam int FD = DEF_FIFO_DEPTH;

   logic                   clk = 1'b0;
   logic                   rst_n;
   logic                   enable;
   logic                   start;
   logic [SW-1:0]          shift;
   logic                   relu_en;
   logic signed [AW*N-1:0] bias;
   logic signed [AW*N-1:0] c_in;
   logic                   busy;
   logic                   output_read;
   logic                   q_valid;
   logic                   q_ready;
   logic signed [OW*N-1:0] q_data;
   logic                   q_last;

   always #5 clk = ~clk;

   output_requant #(
      .ARRAY_SIZE  (N),
      .ACC_WIDTH   (AW),
      .OUT_WIDTH   (OW),
      .SHIFT_WIDTH (SW),
      .FIFO_DEPTH  (FD)
   ) dut (
      .clk         (clk),
      .rst         (rst_n),
      .enable      (enable),
      .start       (start),
      .shift       (shift),
      .relu_en     (relu_en),
      .bias        (bias),
      .busy        (busy),
      .output_read (output_read),
      .c_in        (c_in),
      .q_valid     (q_valid),
      .q_ready     (q_ready),
      .q_data      (q_data),
      .q_last      (q_last)
   );

   int          n_checks = 0;
   int          n_errors = 0;
   int          tile [N][N];
   int          bias_col [N];
   q_row_t      exp_q [$];
   logic        exp_last_q [$];
   int          pop_log [$];
   int          cyc = 0;
   int          rd_idx = 0;
   int          n_reads = 0;
   logic        s_busy = 1'b0;
   logic        s_read = 1'b0;
   logic        prev_hold = 1'b0;
   logic [63:0] prev_data = '0;
   logic        busy_log [128];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference arithmetic: exact integer sum, floor((s + d/2) / d), clamp.
   function automatic logic [OW-1:0] model(input longint c, input longint b, input int sh, input bit relu);
      longint s, r, d, x;
      s = c + b;
      if (sh > 0) begin
         d = longint'(1) << sh;
         x = s + d / 2;
         r = x / d;
         if ((x % d != 0) && (x < 0)) r = r - 1;
      end else begin
         r = s;
      end
      if (relu && r < 0) r = 0;
      if (r > 127) r = 127;
      if (r < -128) r = -128;
      return r[OW-1:0];
   endfunction

   function automatic int pop_at(input int i);
      return (i < pop_log.size()) ? pop_log[i] : -1;
   endfunction

   function automatic int rand_val();
      case ($urandom_range(0, 3))
         0:       return int'($urandom_range(0, 1023)) - 512;
         1:       return int'($urandom_range(0, 131071)) - 65536;
         2:       return int'($urandom);
         default: return ($urandom_range(0, 1) != 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
      endcase
   endfunction

   task automatic step();
      @(negedge clk);
      s_busy = busy;
      s_read = output_read;
      if (cyc < 128) busy_log[cyc] = busy;
      if (!enable) check("read_in_stall", output_read, 0);
      if (prev_hold) begin
         check("hold_valid", q_valid, 1);
         check("hold_data", q_data, prev_data);
      end
      prev_hold = q_valid & ~q_ready;
      prev_data = q_data;
      if (output_read) begin
         n_reads++;
         check("read_in_range", rd_idx < N, 1);
      end
      if (q_valid && q_ready) begin
         pop_log.push_back(cyc);
         check("row_expected", exp_q.size() != 0, 1);
         if (exp_q.size() != 0) begin
            check("q_data", q_data, exp_q.pop_front());
            check("q_last", q_last, exp_last_q.pop_front());
         end
      end
      @(posedge clk);
      #1;
      if (s_read && rd_idx < N) begin
         for (int j = 0; j < N; j++) c_in[j*AW +: AW] = tile[rd_idx][j];
         rd_idx++;
      end
      cyc++;
   endtask

   task automatic start_tile(input int sh, input bit relu);
      q_row_t row;
      shift   = SW'(sh);
      relu_en = relu;
      for (int j = 0; j < N; j++) bias[j*AW +: AW] = bias_col[j];
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) row[j] = model(tile[i][j], bias_col[j], sh, relu);
         exp_q.push_back(row);
         exp_last_q.push_back(i == N - 1);
      end
      cyc = 0;
      rd_idx = 0;
      n_reads = 0;
      pop_log.delete();
      start = 1'b1;
      step();
      start = 1'b0;
      shift   = SW'($urandom);
      relu_en = ~relu;
      for (int j = 0; j < N; j++) bias[j*AW +: AW] = rand_val();
   endtask

   task automatic run_idle(input int budget, input bit rnd);
      int k;
      k = 0;
      while (k < budget && !(cyc > 1 && !s_busy)) begin
         if (rnd) begin
            q_ready = ($urandom_range(0, 3) != 0);
            enable  = ($urandom_range(0, 4) != 0);
         end
         step();
         k++;
      end
      check("reached_idle", s_busy, 0);
      enable  = 1'b1;
      q_ready = 1'b1;
   endtask

   task automatic tile_done(input string tag);
      check({tag, "_rows_left"}, exp_q.size(), 0);
      check({tag, "_reads"}, n_reads, N);
      check({tag, "_pops"}, pop_log.size(), N);
   endtask

   task automatic fill_ramp();
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) tile[i][j] = 16 * i + j;
      end
      for (int j = 0; j < N; j++) bias_col[j] = 0;
   endtask

   task automatic fill_random();
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) tile[i][j] = rand_val();
      end
      for (int j = 0; j < N; j++) bias_col[j] = rand_val();
   endtask

   initial begin
      rst_n = 1'b0; enable = 1'b1; start = 1'b0; q_ready = 1'b1;
      shift = '0; relu_en = 1'b0; bias = '0; c_in = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_read", output_read, 0);
      check("rst_valid", q_valid, 0);
      check("rst_last", q_last, 0);
      check("rst_data", q_data, 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // full throughput, ramp tile
      fill_ramp();
      start_tile(0, 1'b0);
      run_idle(60, 1'b0);
      tile_done("thru");
      check("thru_first_row", pop_at(0), 4);
      check("thru_last_row", pop_at(N - 1), N + 3);
      check("thru_busy_c1", busy_log[1], 1);
      check("thru_busy_fall", cyc - 1, N + 4);

      // arithmetic with shift 4
      fill_random();
      for (int j = 0; j < N; j++) bias_col[j] = 0;
      tile[0][0] = 1000; bias_col[0] = 24;
      tile[0][1] = 24;
      tile[0][2] = -24;
      tile[0][3] = 5000;
      start_tile(4, 1'b0);
      run_idle(60, 1'b0);
      tile_done("arith");

      // shift 0 with and without ReLU
      for (int r = 0; r < 2; r++) begin
         fill_random();
         for (int j = 0; j < N; j++) bias_col[j] = 0;
         tile[0][0] = -300;
         tile[0][1] = 100;
         start_tile(0, r == 0);
         run_idle(60, 1'b0);
         tile_done("relu");
      end

      // back-pressure
      fill_ramp();
      q_ready = 1'b0;
      start_tile(0, 1'b0);
      repeat (19) step();
      check("bp_reads", n_reads, FD);
      check("bp_valid", q_valid, 1);
      check("bp_head", q_data, exp_q[0]);
      q_ready = 1'b1;
      run_idle(80, 1'b0);
      tile_done("bp");

      // enable stall of 3 cycles mid-drain
      fill_ramp();
      start_tile(0, 1'b0);
      step();
      enable = 1'b0;
      repeat (3) step();
      enable = 1'b1;
      run_idle(60, 1'b0);
      tile_done("stall");
      check("stall_first_row", pop_at(0), 7);
      check("stall_last_row", pop_at(N - 1), N + 6);
      check("stall_busy_fall", cyc - 1, N + 7);

      // asynchronous reset after row 3 pops
      fill_random();
      start_tile($urandom_range(0, 12), 1'b0);
      for (int k = 0; k < 40 && pop_log.size() < 4; k++) step();
      check("pre_rst_pops", pop_log.size(), 4);
      rst_n = 1'b0;
      #1;
      check("mid_rst_busy", busy, 0);
      check("mid_rst_read", output_read, 0);
      check("mid_rst_valid", q_valid, 0);
      check("mid_rst_last", q_last, 0);
      check("mid_rst_data", q_data, 0);
      exp_q.delete();
      exp_last_q.delete();
      prev_hold = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      fill_random();
      start_tile($urandom_range(0, 31), $urandom_range(0, 1) != 0);
      run_idle(60, 1'b0);
      tile_done("post_rst");

      // start pulsed while busy is ignored
      fill_random();
      start_tile(3, 1'b0);
      repeat (2) step();
      start = 1'b1;
      step();
      start = 1'b0;
      run_idle(60, 1'b0);
      tile_done("restart");
      repeat (3) step();
      check("restart_idle", s_busy, 0);
      check("restart_reads", n_reads, N);

      // randomized tiles with random back-pressure and stalls
      for (int t = 0; t < 8; t++) begin
         fill_random();
         start_tile($urandom_range(0, 31), $urandom_range(0, 1) != 0);
         run_idle(400, 1'b1);
         tile_done("rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule
